// File: rtl/nfu3_pkg.sv
// Shared NFU-3 constants and the coefficient-loader state type.
package nfu3_pkg;

  localparam int unsigned BIT_WIDTH  = 16;
  localparam int unsigned NUM_SEG    = 16;
  localparam int unsigned SEG_ADDR_W = $clog2(NUM_SEG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } coef_ld_state_t;

endpackage

// File: rtl/nfu3_coef_loader.sv
// Streams NUM_SEG {Ai,Bi} pairs into the NFU-3 coefficient RAMs after a start request.
// Optional running checksum output enabled by NFU3_COEF_CHECKSUM_EN.
module nfu3_coef_loader #(
  parameter int unsigned BIT_WIDTH = nfu3_pkg::BIT_WIDTH,
  parameter int unsigned NUM_SEG   = nfu3_pkg::NUM_SEG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_coef_valid,
  input  logic [2*BIT_WIDTH-1:0]     i_coef_data,
  output logic                       o_coef_ready,
  output logic [2*BIT_WIDTH-1:0]     o_coef,
  output logic [$clog2(NUM_SEG)-1:0] o_coef_addr,
  output logic                       o_load_coef,
  output logic                       o_busy,
`ifdef NFU3_COEF_CHECKSUM_EN
  output logic [BIT_WIDTH-1:0]       o_checksum,
`endif
  output logic                       o_done
);
  import nfu3_pkg::*;

  localparam int unsigned           ADDR_W   = $clog2(NUM_SEG);
  localparam logic [ADDR_W-1:0]     LAST_SEG = ADDR_W'(NUM_SEG - 1);

  coef_ld_state_t    state, state_nxt;
  logic [ADDR_W-1:0] seg_cnt;
  logic              xfer;
  logic              start_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_coef_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    xfer         = 1'b0;
    start_ok     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          start_ok  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_coef_ready = 1'b1;
        o_busy       = 1'b1;
        xfer         = i_coef_valid;
        if (i_coef_valid && seg_cnt == LAST_SEG) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter holds at the last index on the final transfer; a new start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_cnt     <= '0;
      o_coef      <= '0;
      o_coef_addr <= '0;
      o_load_coef <= 1'b0;
    end else begin
      o_load_coef <= xfer;
      if (start_ok) seg_cnt <= '0;
      if (xfer) begin
        o_coef      <= i_coef_data;
        o_coef_addr <= seg_cnt;
        if (seg_cnt != LAST_SEG) seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

`ifdef NFU3_COEF_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_checksum <= '0;
    end else if (start_ok) begin
      o_checksum <= '0;
    end else if (xfer) begin
      o_checksum <= o_checksum + i_coef_data[2*BIT_WIDTH-1:BIT_WIDTH]
                               + i_coef_data[BIT_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_nfu3_coef_loader.sv
// Randomized and directed checks of nfu3_coef_loader against a pair-counting reference model.
module tb_nfu3_coef_loader;

  localparam int NSEG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_coef_valid;
  logic [31:0] i_coef_data;
  logic        o_coef_ready;
  logic [31:0] o_coef;
  logic [3:0]  o_coef_addr;
  logic        o_load_coef;
  logic        o_busy;
  logic        o_done;
`ifdef NFU3_COEF_CHECKSUM_EN
  logic [15:0] o_checksum;
`endif

  nfu3_coef_loader #(.BIT_WIDTH(16), .NUM_SEG(NSEG)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_coef_valid (i_coef_valid),
    .i_coef_data  (i_coef_data),
    .o_coef_ready (o_coef_ready),
    .o_coef       (o_coef),
    .o_coef_addr  (o_coef_addr),
    .o_load_coef  (o_load_coef),
    .o_busy       (o_busy),
`ifdef NFU3_COEF_CHECKSUM_EN
    .o_checksum   (o_checksum),
`endif
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: "loading" plus number of pairs accepted so far.
  bit          m_loading = 0;
  bit          m_done    = 0;
  bit          m_strobe  = 0;
  int          m_n       = 0;
  int          m_addr    = 0;
  logic [31:0] m_coef    = '0;
  logic [15:0] m_sum     = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("load_coef", 64'(o_load_coef), 64'(m_strobe));
    chk("coef", 64'(o_coef), 64'(m_coef));
    chk("coef_addr", 64'(o_coef_addr), 64'(m_addr));
    chk("done", 64'(o_done), 64'(m_done));
    chk("busy", 64'(o_busy), 64'(m_loading || m_done));
    chk("ready", 64'(o_coef_ready), 64'(m_loading));
`ifdef NFU3_COEF_CHECKSUM_EN
    chk("checksum", 64'(o_checksum), 64'(m_sum));
`endif
  endtask

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_strobe = 0;
    m_n = 0; m_addr = 0; m_coef = '0; m_sum = '0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic step(input logic s, input logic v, input logic [31:0] d);
    bit prev_done;
    i_start = s; i_coef_valid = v; i_coef_data = d;
    @(posedge clk);
    prev_done = m_done;
    m_strobe  = 0;
    m_done    = 0;
    if (m_loading) begin
      if (v) begin
        m_coef   = d;
        m_addr   = m_n;
        m_strobe = 1;
        m_sum    = m_sum + d[31:16] + d[15:0];
        m_n++;
        if (m_n == NSEG) begin
          m_loading = 0;
          m_done    = 1;
        end
      end
    end else if (!prev_done && s) begin
      m_loading = 1;
      m_n       = 0;
      m_sum     = '0;
    end
    #1;
    check_outputs();
  endtask

  // mode 0: back-to-back {k,k+100}; 1: valid 1,0,0,1; 2: random; 3: start at transfer 5;
  // 4: constant {0x1000,0x0001}. stop_after>0 abandons the load after that many transfers.
  task automatic run_load(input int mode, input int stop_after);
    int          cyc;
    int          strobes;
    logic        v;
    logic        s;
    logic [31:0] d;
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    cyc = 0;
    strobes = 0;
    while (m_loading && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      case (mode)
        0, 1:    d = {16'(m_n), 16'(m_n + 100)};
        4:       d = 32'h1000_0001;
        default: d = $urandom;
      endcase
      s = (mode == 3 && m_n == 5 && v) ? 1'b1 : 1'b0;
      step(s, v, d);
      if (o_load_coef) strobes++;
      cyc++;
      if (stop_after > 0 && m_n == stop_after) break;
    end
    chk("load_within_budget", 64'(cyc < 200), 64'd1);
    if (stop_after == 0) chk("strobe_count", 64'(strobes), 64'(NSEG));
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; i_start = 1'b0; i_coef_valid = 1'b0; i_coef_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Valid before any start is ignored.
    repeat (3) step(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("idle_coef_unchanged", 64'(o_coef), 64'd0);

    // Full back-to-back load; last strobe carries addr 15 with o_done.
    run_load(0, 0);
    chk("last_addr", 64'(o_coef_addr), 64'd15);
    chk("last_done", 64'(o_done), 64'd1);
    chk("last_pair", 64'(o_coef), 64'h000F_0073);
    // Valid and start during the done cycle, then valid in idle: all ignored.
    held = o_coef;
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("busy_low_after_done", 64'(o_busy), 64'd0);
    repeat (3) step(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("late_coef_unchanged", 64'(o_coef), 64'(held));

    run_load(1, 0);
    step(1'b0, 1'b0, '0);

    run_load(3, 0);
    step(1'b0, 1'b0, '0);

    // Reset after 7 transfers, then require a fresh start.
    run_load(2, 7);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b1, $urandom);
    run_load(2, 0);
    step(1'b0, 1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      run_load(2, 0);
      repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    step(1'b0, 1'b0, '0);

`ifdef NFU3_COEF_CHECKSUM_EN
    run_load(4, 0);
    chk("checksum_at_done", 64'(o_checksum), 64'h0010);
    step(1'b0, 1'b0, '0);
    chk("checksum_held", 64'(o_checksum), 64'h0010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/nfu3_coef_loader.md
NFU3_COEF_LOADER -- requirements
Module: nfu3_coef_loader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning width of one coefficient (Ai or Bi).
REQ-002 SHALL have parameter NUM_SEG, default 16, meaning number of piecewise sigmoid segments (table depth).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_start  input  1  one-cycle request to begin a full table load.
REQ-007 SHALL have port i_coef_valid  input  1  source has a coefficient pair on i_coef_data.
REQ-008 SHALL have port i_coef_data  input  2*BIT_WIDTH  packed {Ai, Bi}, Ai in the upper half.
REQ-009 SHALL have port o_coef_ready  output  1  loader accepts a pair this cycle.
REQ-010 SHALL have port o_coef  output  2*BIT_WIDTH  registered pair driven to the NFU-3 coefficient inputs.
REQ-011 SHALL have port o_coef_addr  output  log2(NUM_SEG)  segment index of o_coef.
REQ-012 SHALL have port o_load_coef  output  1  write strobe to the NFU-3 coefficient RAMs.
REQ-013 SHALL have port o_busy  output  1  high while a load is in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse after the last pair is written.

Function
REQ-015 SHALL implement the FSM IDLE -> LOAD -> DONE -> IDLE.
REQ-016 SHALL move from IDLE to LOAD on i_start and clear the segment counter to 0.
REQ-017 SHALL ignore i_start in LOAD and DONE.
REQ-018 SHALL drive o_coef_ready high only in LOAD, combinationally from state.
REQ-019 SHALL treat a transfer as i_coef_valid and o_coef_ready both high on a rising edge.
REQ-020 SHALL, on a transfer at edge N, show o_coef=i_coef_data, o_coef_addr=counter and o_load_coef=1 during cycle N+1, for exactly one cycle.
REQ-021 SHALL hold o_coef and o_coef_addr stable when no transfer occurs, with o_load_coef=0.
REQ-022 SHALL increment the counter per transfer and move to DONE on the transfer with counter=NUM_SEG-1, with no wrap to 0 inside LOAD.
REQ-023 SHALL assert o_done for the single DONE cycle, coincident with the final o_load_coef, then return to IDLE.
REQ-024 SHALL assert o_busy in LOAD and DONE.
REQ-025 SHALL ignore i_coef_valid in IDLE and DONE: no strobe, no counter change.
REQ-026 SHALL tolerate arbitrary valid gaps (bubbles) in LOAD without changing the counter or emitting strobes.

Reset
REQ-027 SHALL, on rst at any time, force state=IDLE, counter=0, o_coef=0, o_coef_addr=0, o_load_coef=0, o_busy=0, o_done=0.
REQ-028 SHALL discard a partially loaded table on reset mid-LOAD: no o_done, no further strobes, and a new i_start is required.

Configuration
REQ-029 SHALL, with NFU3_COEF_CHECKSUM_EN defined, add output o_checksum (BIT_WIDTH), the modulo-2^BIT_WIDTH sum of Ai+Bi over all accepted pairs.
REQ-030 SHALL clear o_checksum on i_start accepted in IDLE and on reset, and hold it valid from the o_done cycle until the next start.
REQ-031 SHALL, without NFU3_COEF_CHECKSUM_EN, omit the o_checksum port and its adder entirely.

Structure
REQ-032 SHALL take BIT_WIDTH, NUM_SEG, SEG_ADDR_W and the FSM state typedef from shared package nfu3_pkg, used by the NFU-3 datapath too.
REQ-033 SHALL be a single module with no sub-modules; counter, FSM and output register are inline.

Verification
REQ-034 SHALL cover a full load: start, then 16 back-to-back pairs {k,k+100} -> 16 strobes at addr 0..15 one cycle after each transfer, o_done with the 16th strobe, o_busy low the next cycle.
REQ-035 SHALL cover bubbles: valid toggled 1,0,0,1 throughout -> exactly 16 strobes, addresses consecutive, no duplicates.
REQ-036 SHALL cover early and late valid: valid=1 with pair 0xDEAD_BEEF in IDLE and after done -> no strobe, o_coef unchanged.
REQ-037 SHALL cover reset mid-load: rst after 7 transfers -> outputs zero, no o_done; a restart then loads addresses 0..15.
REQ-038 SHALL cover start during busy: i_start pulsed at transfer 5 -> ignored, load completes normally.
REQ-039 SHALL cover checksum (macro on): pairs {0x1000,0x0001} x16 -> o_checksum=0x0010 at o_done.
